// File: rtl/inst_mem_pipelined_pkg.sv
// Shared types and constants for the pipelined instruction memory.
package inst_mem_pipelined_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Misaligned PC or any address bit above the array depth.
  function automatic logic fetch_fault(logic [XLEN-1:0] pc, int unsigned addr_w);
    return (pc[1:0] != 2'b00) || ((pc >> addr_w) != '0);
  endfunction

endpackage

// File: rtl/inst_mem_pipelined_imem_byte_array.sv
// Byte RAM with one write port and a registered little-endian 4-byte word read.
module imem_byte_array #(
  parameter int unsigned AddrW    = 12,
  parameter string       InitFile = ""
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_en_i,
  input  logic [AddrW-1:0] ld_addr_i,
  input  logic [7:0]       ld_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-3:0] rd_addr_i,
  output logic [31:0]      rd_data_o
);

  logic [7:0]  mem [2**AddrW];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (ld_en_i) mem[ld_addr_i] <= ld_data_i;
  end

  // Non-blocking update gives read-before-write on a same-edge load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= {mem[{rd_addr_i, 2'd3}], mem[{rd_addr_i, 2'd2}],
                    mem[{rd_addr_i, 2'd1}], mem[{rd_addr_i, 2'd0}]};
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_mem_pipelined.sv
// Instruction memory with valid/ready fetch, configurable wait states, flush and load port.
module inst_mem_pipelined
  import inst_mem_pipelined_pkg::*;
#(
  parameter int unsigned     ADDR_W      = 12,
  parameter int unsigned     WAIT_CYCLES = 1,
  parameter string           INIT_FILE   = "./hex/test1_mem.hex",
  parameter logic [XLEN-1:0] NOP_WORD    = RV32_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_pc,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_pc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              err_q, err_d;
  logic              accept;
  logic              capture;
  logic [ADDR_W-3:0] rd_word_addr;
  logic [31:0]       rd_word;

  assign req_ready = !rst && !flush &&
                     (state_q == StIdle || (state_q == StResp && resp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    err_d        = err_q;
    capture      = 1'b0;
    rd_word_addr = pc_q[ADDR_W-1:2];
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if (state_q == StResp && resp_ready) state_d = StIdle;
          // Accept from IDLE or back-to-back on the RESP handshake.
          if (accept) begin
            pc_d  = req_pc;
            err_d = fetch_fault(req_pc, ADDR_W);
            if (WAIT_CYCLES == 0) begin
              state_d      = StResp;
              capture      = 1'b1;
              rd_word_addr = req_pc[ADDR_W-1:2];
            end else begin
              state_d = StWait;
              cnt_d   = 4'(WAIT_CYCLES - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StResp;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  imem_byte_array #(
    .AddrW    (ADDR_W),
    .InitFile (INIT_FILE)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .rd_en_i   (capture),
    .rd_addr_i (rd_word_addr),
    .rd_data_o (rd_word)
  );

  assign resp_valid = (state_q == StResp);
  assign resp_data  = err_q ? NOP_WORD : rd_word;
  assign resp_err   = err_q;
  assign resp_pc    = pc_q;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Directed bench: three instances with WAIT_CYCLES = 1, 0, 3 sharing clock and reset.
module tb_inst_mem_pipelined;

  localparam int unsigned ADDR_W = 12;
  localparam logic [11:0] WAITS  = {4'd3, 4'd0, 4'd1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_pc     [3];
  logic        flush      [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_data  [3];
  logic        resp_err   [3];
  logic [31:0] resp_pc    [3];
  logic        ld_en      [3];
  logic [11:0] ld_addr    [3];
  logic [7:0]  ld_data    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_mem_pipelined #(
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (int'(WAITS[g*4 +: 4])),
      .INIT_FILE   ("")
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_pc     (req_pc[g]),
      .flush      (flush[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_err   (resp_err[g]),
      .resp_pc    (resp_pc[g]),
      .ld_en      (ld_en[g]),
      .ld_addr    (ld_addr[g]),
      .ld_data    (ld_data[g])
    );
  end

  typedef struct {
    int          d;
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int d, input logic [11:0] addr, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      ld_en[d]   = 1'b1;
      ld_addr[d] = addr + 12'(b);
      ld_data[d] = word[b*8 +: 8];
      step();
    end
    ld_en[d] = 1'b0;
  endtask

  // lat counts edges after the accept edge before resp_valid is seen,
  // so resp_valid is sampled high at edge T+1+lat.
  task automatic fetch(input int d, input logic [31:0] pc, output logic [31:0] data,
                       output logic err, output logic [31:0] rpc, output int lat);
    int n;
    req_valid[d]  = 1'b1;
    req_pc[d]     = pc;
    resp_ready[d] = 1'b0;
    #1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      step();
      n++;
    end
    check("accept_wait", 32'(req_ready[d]), 32'd1);
    step();
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin
      step();
      lat++;
    end
    data = resp_data[d];
    err  = resp_err[d];
    rpc  = resp_pc[d];
    resp_ready[d] = 1'b1;
    step();
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] data, rpc, ref_data, ref_pc;
    logic        err;
    int          lat, cnt, cnt2;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_pc[i] = 0; flush[i] = 0; resp_ready[i] = 0;
      ld_en[i] = 0; ld_addr[i] = 0; ld_data[i] = 0;
    end

    vecs[0] = '{0, 32'h0000_0000, 32'h0000_2083, 1'b0, 1};
    vecs[1] = '{0, 32'h0000_0004, 32'h0010_0093, 1'b0, 1};
    vecs[2] = '{0, 32'h0000_0002, 32'h0000_0013, 1'b1, 1};
    vecs[3] = '{0, 32'h0000_1000, 32'h0000_0013, 1'b1, 1};
    vecs[4] = '{1, 32'h0000_0008, 32'h0020_0113, 1'b0, 0};
    vecs[5] = '{1, 32'h8000_0000, 32'h0000_0013, 1'b1, 0};
    vecs[6] = '{2, 32'h0000_0004, 32'h0010_0093, 1'b0, 3};
    vecs[7] = '{2, 32'h0000_0001, 32'h0000_0013, 1'b1, 3};
    vecs[8] = '{2, 32'h0000_0000, 32'h0000_2083, 1'b0, 3};

    // Reset
    step(); step();
    check("ready_in_reset", 32'(req_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_data", resp_data[d], 32'd0);
      check("rst_err", 32'(resp_err[d]), 32'd0);
      check("rst_pc", resp_pc[d], 32'd0);
    end

    for (int d = 0; d < 3; d++) begin
      load_word(d, 12'h000, 32'h0000_2083);
      load_word(d, 12'h004, 32'h0010_0093);
      load_word(d, 12'h008, 32'h0020_0113);
    end

    // Table-driven fetches
    for (int i = 0; i < 9; i++) begin
      fetch(vecs[i].d, vecs[i].pc, data, err, rpc, lat);
      check("vec_data", data, vecs[i].data);
      check("vec_err", 32'(err), 32'(vecs[i].err));
      check("vec_pc", rpc, vecs[i].pc);
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
    end

    // Back-to-back at WAIT_CYCLES=0
    req_valid[1] = 1; req_pc[1] = 32'h0; resp_ready[1] = 1;
    step();
    check("b2b_pc0", resp_pc[1], 32'h0);
    check("b2b_data0", resp_data[1], 32'h0000_2083);
    req_pc[1] = 32'h4;
    #1;
    check("b2b_ready_in_resp", 32'(req_ready[1]), 32'd1);
    step();
    check("b2b_valid4", 32'(resp_valid[1]), 32'd1);
    check("b2b_data4", resp_data[1], 32'h0010_0093);
    req_pc[1] = 32'h8;
    step();
    check("b2b_pc8", resp_pc[1], 32'h8);
    check("b2b_data8", resp_data[1], 32'h0020_0113);
    req_valid[1] = 0;
    step();
    check("b2b_idle", 32'(resp_valid[1]), 32'd0);
    resp_ready[1] = 0;

    // Backpressure hold for 5 cycles, then a single handshake
    req_valid[0] = 1; req_pc[0] = 32'h8;
    step();
    req_valid[0] = 0;
    cnt = 0;
    while (!resp_valid[0] && cnt < 40) begin step(); cnt++; end
    ref_data = resp_data[0];
    ref_pc = resp_pc[0];
    check("hold_data", ref_data, 32'h0020_0113);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!resp_valid[0] || resp_data[0] !== ref_data || resp_pc[0] !== ref_pc) cnt++;
      if (req_ready[0]) cnt2++;
    end
    check("hold_unstable", 32'(cnt), 32'd0);
    check("hold_ready_high", 32'(cnt2), 32'd0);
    resp_ready[0] = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid[0] && resp_ready[0]) cnt++;
      step();
    end
    check("hold_handshakes", 32'(cnt), 32'd1);
    resp_ready[0] = 0;

    // Flush one cycle after acceptance at WAIT_CYCLES=3
    req_valid[2] = 1; req_pc[2] = 32'h0;
    step();
    req_pc[2] = 32'h8; flush[2] = 1;
    #1;
    check("flush_ready", 32'(req_ready[2]), 32'd0);
    step();
    flush[2] = 0; req_valid[2] = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid[2]) cnt++;
      step();
    end
    check("flush_no_resp", 32'(cnt), 32'd0);
    fetch(2, 32'h4, data, err, rpc, lat);
    check("post_flush_data", data, 32'h0010_0093);
    check("post_flush_latency", 32'(lat), 32'd3);

    // Same-edge load and capture returns old data
    req_valid[0] = 1; req_pc[0] = 32'h0;
    step();
    req_valid[0] = 0;
    ld_en[0] = 1; ld_addr[0] = 12'h000; ld_data[0] = 8'hAA;
    step();
    ld_en[0] = 0;
    check("collide_valid", 32'(resp_valid[0]), 32'd1);
    check("collide_old", resp_data[0], 32'h0000_2083);
    resp_ready[0] = 1; step(); resp_ready[0] = 0;
    fetch(0, 32'h0, data, err, rpc, lat);
    check("collide_new", data, 32'h0000_20AA);

    // Load during WAIT to the pending word is visible
    req_valid[2] = 1; req_pc[2] = 32'h4;
    step();
    req_valid[2] = 0;
    ld_en[2] = 1; ld_addr[2] = 12'h005; ld_data[2] = 8'h22;
    step();
    ld_en[2] = 0;
    cnt = 0;
    while (!resp_valid[2] && cnt < 40) begin step(); cnt++; end
    check("wait_load_data", resp_data[2], 32'h0010_2293);
    resp_ready[2] = 1; step(); resp_ready[2] = 0;

    // Load port program, fetch, reset mid-WAIT, refetch
    load_word(2, 12'h010, 32'h0000_0513);
    fetch(2, 32'h10, data, err, rpc, lat);
    check("ld_fetch", data, 32'h0000_0513);
    req_valid[2] = 1; req_pc[2] = 32'h10;
    step();
    req_valid[2] = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    check("rst_mid_valid", 32'(resp_valid[2]), 32'd0);
    check("rst_mid_idle", 32'(req_ready[2]), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid[2]) cnt++;
      step();
    end
    check("rst_mid_dropped", 32'(cnt), 32'd0);
    fetch(2, 32'h10, data, err, rpc, lat);
    check("rst_mem_kept", data, 32'h0000_0513);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
